// File: rtl/id_ex_stage_if.sv
// Bundle between decode, hazard unit, later stages and the E stage.
// The stage itself takes the slave side.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              StallE;
  logic              FlushE;
  logic [DATA_W-1:0] RD1D;
  logic [DATA_W-1:0] RD2D;
  logic [DATA_W-1:0] SignImmD;
  logic [REG_W-1:0]  RsD;
  logic [REG_W-1:0]  RtD;
  logic [REG_W-1:0]  RdD;
  logic [4:0]        ShamtD;
  logic [2:0]        ALUControlD;
  logic              ALUSrcD;
  logic              ShiftD;
  logic              RegDstD;
  logic              RegWriteD;
  logic              MemWriteD;
  logic              MemtoRegD;
  logic [DATA_W-1:0] ALUOutM;
  logic [REG_W-1:0]  WriteRegM;
  logic              RegWriteM;
  logic [DATA_W-1:0] ResultW;
  logic [REG_W-1:0]  WriteRegW;
  logic              RegWriteW;
  logic [DATA_W-1:0] SrcAE;
  logic [DATA_W-1:0] SrcBE;
  logic [2:0]        ALUControlE;
  logic [DATA_W-1:0] WriteDataE;
  logic [REG_W-1:0]  WriteRegE;
  logic              RegWriteE;
  logic              MemWriteE;
  logic              MemtoRegE;
  logic [REG_W-1:0]  RsE;
  logic [REG_W-1:0]  RtE;
  logic              ValidE;

  modport master (
    output StallE, FlushE,
    output RD1D, RD2D, SignImmD,
    output RsD, RtD, RdD, ShamtD,
    output ALUControlD, ALUSrcD, ShiftD,
    output RegDstD, RegWriteD,
    output MemWriteD, MemtoRegD,
    output ALUOutM, WriteRegM, RegWriteM,
    output ResultW, WriteRegW, RegWriteW,
    input  SrcAE, SrcBE, ALUControlE,
    input  WriteDataE, WriteRegE,
    input  RegWriteE, MemWriteE, MemtoRegE,
    input  RsE, RtE, ValidE
  );

  modport slave (
    input  StallE, FlushE,
    input  RD1D, RD2D, SignImmD,
    input  RsD, RtD, RdD, ShamtD,
    input  ALUControlD, ALUSrcD, ShiftD,
    input  RegDstD, RegWriteD,
    input  MemWriteD, MemtoRegD,
    input  ALUOutM, WriteRegM, RegWriteM,
    input  ResultW, WriteRegW, RegWriteW,
    output SrcAE, SrcBE, ALUControlE,
    output WriteDataE, WriteRegE,
    output RegWriteE, MemWriteE, MemtoRegE,
    output RsE, RtE, ValidE
  );
endinterface

// File: rtl/id_ex_stage.sv
// Decode-to-execute register with MEM/WB forwarding
// and ALU operand selection.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input logic           clk,
  input logic           reset,
  id_ex_stage_if.slave  bus
);

  typedef struct packed {
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [4:0]        shamt;
    logic [2:0]        alu_ctl;
    logic              alu_src;
    logic              shift;
    logic              reg_dst;
    logic              reg_write;
    logic              mem_write;
    logic              mem_to_reg;
    logic              valid;
  } id_ex_t;

  id_ex_t d;
  id_ex_t e_q;

  always_comb begin
    d            = '0;
    d.rd1        = bus.RD1D;
    d.rd2        = bus.RD2D;
    d.imm        = bus.SignImmD;
    d.rs         = bus.RsD;
    d.rt         = bus.RtD;
    d.rd         = bus.RdD;
    d.shamt      = bus.ShamtD;
    d.alu_ctl    = bus.ALUControlD;
    d.alu_src    = bus.ALUSrcD;
    d.shift      = bus.ShiftD;
    d.reg_dst    = bus.RegDstD;
    d.reg_write  = bus.RegWriteD;
    d.mem_write  = bus.MemWriteD;
    d.mem_to_reg = bus.MemtoRegD;
    d.valid      = 1'b1;
  end

  // An all-zero entry is the sll $0,$0,0 bubble.
  always_ff @(posedge clk) begin
    if (reset)
      e_q <= '0;
    else if (bus.FlushE)
      e_q <= '0;
    else if (!bus.StallE)
      e_q <= d;
  end

  logic              a_m;
  logic              a_w;
  logic              b_m;
  logic              b_w;
  logic [DATA_W-1:0] fa;
  logic [DATA_W-1:0] fb;

  // MEM beats WB; register 0 is never forwarded.
  always_comb begin
    a_m = (e_q.rs != '0) && bus.RegWriteM
       && (e_q.rs == bus.WriteRegM);
    a_w = (e_q.rs != '0) && bus.RegWriteW
       && (e_q.rs == bus.WriteRegW) && !a_m;
    b_m = (e_q.rt != '0) && bus.RegWriteM
       && (e_q.rt == bus.WriteRegM);
    b_w = (e_q.rt != '0) && bus.RegWriteW
       && (e_q.rt == bus.WriteRegW) && !b_m;
  end

  always_comb begin
    fa = e_q.rd1;
    unique case (1'b1)
      a_m:     fa = bus.ALUOutM;
      a_w:     fa = bus.ResultW;
      default: fa = e_q.rd1;
    endcase
  end

  always_comb begin
    fb = e_q.rd2;
    unique case (1'b1)
      b_m:     fb = bus.ALUOutM;
      b_w:     fb = bus.ResultW;
      default: fb = e_q.rd2;
    endcase
  end

  assign bus.SrcAE = e_q.shift
                   ? {{(DATA_W-5){1'b0}}, e_q.shamt}
                   : fa;
  assign bus.SrcBE = e_q.alu_src ? e_q.imm : fb;
  assign bus.WriteDataE  = fb;
  assign bus.WriteRegE   = e_q.reg_dst ? e_q.rd : e_q.rt;
  assign bus.ALUControlE = e_q.alu_ctl;
  assign bus.RegWriteE   = e_q.reg_write;
  assign bus.MemWriteE   = e_q.mem_write;
  assign bus.MemtoRegE   = e_q.mem_to_reg;
  assign bus.RsE         = e_q.rs;
  assign bus.RtE         = e_q.rt;
  assign bus.ValidE      = e_q.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, forwarding,
// operand muxing, stall/flush and destination select.
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic reset;
  int   ncmp = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .REG_W(5)) bus ();

  id_ex_stage #(.DATA_W(32), .REG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.StallE      = 0;
    bus.FlushE      = 0;
    bus.RD1D        = 0;
    bus.RD2D        = 0;
    bus.SignImmD    = 0;
    bus.RsD         = 0;
    bus.RtD         = 0;
    bus.RdD         = 0;
    bus.ShamtD      = 0;
    bus.ALUControlD = 0;
    bus.ALUSrcD     = 0;
    bus.ShiftD      = 0;
    bus.RegDstD     = 0;
    bus.RegWriteD   = 0;
    bus.MemWriteD   = 0;
    bus.MemtoRegD   = 0;
    bus.ALUOutM     = 0;
    bus.WriteRegM   = 0;
    bus.RegWriteM   = 0;
    bus.ResultW     = 0;
    bus.WriteRegW   = 0;
    bus.RegWriteW   = 0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    clear_inputs();
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      r = $urandom;
      bus.RD1D        = $urandom;
      bus.RD2D        = $urandom;
      bus.SignImmD    = $urandom;
      bus.RsD         = r[4:0];
      bus.RtD         = r[9:5];
      bus.RdD         = r[14:10];
      bus.ShamtD      = r[19:15];
      bus.ALUControlD = r[22:20];
      bus.ALUSrcD     = r[23];
      bus.ShiftD      = r[24];
      bus.RegDstD     = r[25];
      bus.RegWriteD   = 1;
      bus.MemWriteD   = 1;
      bus.MemtoRegD   = 1;
      bus.ALUOutM     = $urandom;
      bus.ResultW     = $urandom;
      bus.WriteRegM   = r[4:0];
      bus.WriteRegW   = r[9:5];
      bus.RegWriteM   = 1;
      bus.RegWriteW   = 1;
      step();
    end
    ncmp++;
    if ({bus.SrcAE, bus.SrcBE, bus.WriteDataE} !== 96'h0) begin
      nerr++;
      $display("FAIL rst_operands got %h %h %h want 0",
               bus.SrcAE, bus.SrcBE, bus.WriteDataE);
    end
    ncmp++;
    if ({bus.ALUControlE, bus.WriteRegE, bus.RsE, bus.RtE}
        !== 18'h0) begin
      nerr++;
      $display("FAIL rst_fields got %h %h %h %h want 0",
               bus.ALUControlE, bus.WriteRegE, bus.RsE, bus.RtE);
    end
    ncmp++;
    if ({bus.RegWriteE, bus.MemWriteE, bus.MemtoRegE,
         bus.ValidE} !== 4'b0) begin
      nerr++;
      $display("FAIL rst_ctrl got %b%b%b%b want 0000",
               bus.RegWriteE, bus.MemWriteE, bus.MemtoRegE,
               bus.ValidE);
    end
    clear_inputs();
    reset = 0;
    bus.RD1D = 5;
    bus.RD2D = 7;
    bus.ALUControlD = 3'd2;
    step();
    ncmp++;
    if (bus.SrcAE !== 32'd5 || bus.SrcBE !== 32'd7) begin
      nerr++;
      $display("FAIL first_load_src got %h %h want 5 7",
               bus.SrcAE, bus.SrcBE);
    end
    ncmp++;
    if (bus.ALUControlE !== 3'd2 || bus.ValidE !== 1'b1) begin
      nerr++;
      $display("FAIL first_load_ctl got %h %b want 2 1",
               bus.ALUControlE, bus.ValidE);
    end
  endtask

  task automatic test_forward_priority();
    clear_inputs();
    bus.RsD  = 8;
    bus.RtD  = 8;
    bus.RD1D = 1;
    bus.RD2D = 2;
    step();
    ncmp++;
    if (bus.SrcAE !== 32'd1 || bus.SrcBE !== 32'd2) begin
      nerr++;
      $display("FAIL fwd_none got %h %h want 1 2",
               bus.SrcAE, bus.SrcBE);
    end
    bus.WriteRegM = 8;
    bus.WriteRegW = 8;
    bus.RegWriteM = 1;
    bus.RegWriteW = 1;
    bus.ALUOutM   = 32'hAA;
    bus.ResultW   = 32'hBB;
    #1;
    ncmp++;
    if (bus.SrcAE !== 32'hAA || bus.SrcBE !== 32'hAA) begin
      nerr++;
      $display("FAIL fwd_mem_wins got %h %h want aa aa",
               bus.SrcAE, bus.SrcBE);
    end
    bus.RegWriteM = 0;
    #1;
    ncmp++;
    if (bus.SrcAE !== 32'hBB || bus.SrcBE !== 32'hBB) begin
      nerr++;
      $display("FAIL fwd_wb got %h %h want bb bb",
               bus.SrcAE, bus.SrcBE);
    end
    bus.RegWriteM = 1;
    bus.WriteRegM = 0;
    bus.WriteRegW = 0;
    bus.RsD  = 0;
    bus.RtD  = 0;
    bus.RD1D = 0;
    bus.RD2D = 0;
    step();
    ncmp++;
    if (bus.SrcAE !== 32'h0 || bus.SrcBE !== 32'h0) begin
      nerr++;
      $display("FAIL fwd_reg0 got %h %h want 0 0",
               bus.SrcAE, bus.SrcBE);
    end
  endtask

  task automatic test_imm_store();
    clear_inputs();
    bus.RtD       = 9;
    bus.RD2D      = 32'h55;
    bus.ALUSrcD   = 1;
    bus.SignImmD  = 32'hFFFF_FFFC;
    bus.WriteRegM = 9;
    bus.RegWriteM = 1;
    bus.ALUOutM   = 32'h1234;
    step();
    ncmp++;
    if (bus.SrcBE !== 32'hFFFF_FFFC) begin
      nerr++;
      $display("FAIL imm_srcb got %h want fffffffc", bus.SrcBE);
    end
    ncmp++;
    if (bus.WriteDataE !== 32'h1234) begin
      nerr++;
      $display("FAIL store_data got %h want 1234",
               bus.WriteDataE);
    end
  endtask

  task automatic test_shift();
    clear_inputs();
    bus.ShiftD    = 1;
    bus.ShamtD    = 5'd31;
    bus.RsD       = 3;
    bus.RD1D      = 32'h77;
    bus.WriteRegM = 3;
    bus.RegWriteM = 1;
    bus.ALUOutM   = 32'hDEAD;
    step();
    ncmp++;
    if (bus.SrcAE !== 32'h0000_001F) begin
      nerr++;
      $display("FAIL shift_srca got %h want 1f", bus.SrcAE);
    end
    bus.ShiftD = 0;
    step();
    ncmp++;
    if (bus.SrcAE !== 32'hDEAD) begin
      nerr++;
      $display("FAIL noshift_fwd got %h want dead", bus.SrcAE);
    end
  endtask

  task automatic test_stall_flush();
    clear_inputs();
    bus.RsD         = 6;
    bus.RtD         = 7;
    bus.RdD         = 12;
    bus.RD1D        = 32'h10;
    bus.RD2D        = 32'h20;
    bus.RegDstD     = 1;
    bus.RegWriteD   = 1;
    bus.MemWriteD   = 1;
    bus.ALUControlD = 3'd5;
    step();
    bus.StallE = 1;
    for (int i = 0; i < 3; i++) begin
      bus.RD1D        = 32'h99 + i;
      bus.RsD         = 5'(1 + i);
      bus.RdD         = 5'(2 + i);
      bus.RegWriteD   = 0;
      bus.MemWriteD   = 0;
      bus.ALUControlD = 3'(i);
      step();
      ncmp++;
      if (bus.SrcAE !== 32'h10 || bus.SrcBE !== 32'h20
          || bus.ALUControlE !== 3'd5 || bus.WriteRegE !== 5'd12
          || bus.RegWriteE !== 1'b1 || bus.MemWriteE !== 1'b1
          || bus.RsE !== 5'd6 || bus.ValidE !== 1'b1) begin
        nerr++;
        $display("FAIL stall_hold%0d got %h %h %h %h %b%b %h %b",
                 i, bus.SrcAE, bus.SrcBE, bus.ALUControlE,
                 bus.WriteRegE, bus.RegWriteE, bus.MemWriteE,
                 bus.RsE, bus.ValidE);
      end
    end
    bus.WriteRegW = 6;
    bus.RegWriteW = 1;
    bus.ResultW   = 32'h4242;
    #1;
    ncmp++;
    if (bus.SrcAE !== 32'h4242) begin
      nerr++;
      $display("FAIL stall_late_fwd got %h want 4242", bus.SrcAE);
    end
    step();
    bus.ResultW = 32'h4343;
    #1;
    ncmp++;
    if (bus.SrcAE !== 32'h4343 || bus.ValidE !== 1'b1) begin
      nerr++;
      $display("FAIL stall_track got %h %b want 4343 1",
               bus.SrcAE, bus.ValidE);
    end
    bus.FlushE    = 1;
    bus.RegWriteD = 1;
    step();
    ncmp++;
    if (bus.RegWriteE !== 1'b0 || bus.MemWriteE !== 1'b0
        || bus.ValidE !== 1'b0 || bus.SrcAE !== 32'h0) begin
      nerr++;
      $display("FAIL flush_bubble got %b%b%b %h want 000 0",
               bus.RegWriteE, bus.MemWriteE, bus.ValidE,
               bus.SrcAE);
    end
  endtask

  task automatic test_write_reg();
    clear_inputs();
    bus.RegDstD = 1;
    bus.RdD     = 17;
    bus.RtD     = 4;
    step();
    ncmp++;
    if (bus.WriteRegE !== 5'd17) begin
      nerr++;
      $display("FAIL wreg_rd got %0d want 17", bus.WriteRegE);
    end
    bus.RegDstD = 0;
    step();
    ncmp++;
    if (bus.WriteRegE !== 5'd4 || bus.RtE !== 5'd4) begin
      nerr++;
      $display("FAIL wreg_rt got %0d %0d want 4 4",
               bus.WriteRegE, bus.RtE);
    end
  endtask

  task automatic test_reset_midflight();
    clear_inputs();
    bus.RsD       = 2;
    bus.RD1D      = 32'h321;
    bus.RegWriteD = 1;
    step();
    reset = 1;
    step();
    reset = 0;
    bus.StallE = 1;
    #1;
    ncmp++;
    if (bus.ValidE !== 1'b0 || bus.RegWriteE !== 1'b0
        || bus.SrcAE !== 32'h0) begin
      nerr++;
      $display("FAIL rst_midflight got %b %b %h want 0 0 0",
               bus.ValidE, bus.RegWriteE, bus.SrcAE);
    end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_forward_priority();
    test_imm_store();
    test_shift();
    test_stall_flush();
    test_write_reg();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
